// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared sizing helpers for the pipelined adder tree
package adder_pkg;

  localparam int MAX_NUM = 64;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

  function automatic int out_bits(input int bits, input int num, input int grow);
    return (grow != 0) ? bits + clog2(num) : bits;
  endfunction

  // Partial-sum count held by stage s; s = -1 yields the raw lane count.
  function automatic int stage_cnt(input int num, input int s);
    return (num + (1 << (s + 1)) - 1) >> (s + 1);
  endfunction

endpackage

// File: rtl/adder_tree_pipe_if.sv
// rtl/adder_tree_pipe_if.sv - valid/ready operand and result bundle of the adder tree
interface adder_tree_pipe_if #(
  parameter int NUM      = 4,
  parameter int BITS     = 8,
  parameter int OUT_BITS = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [NUM*BITS-1:0]  in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_BITS-1:0]  out_data;
  logic                 out_ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/adder_tree_stage.sv
// rtl/adder_tree_stage.sv - one registered tree level: pairwise adds, odd pass-through, valid/ready
module adder_tree_stage
  import adder_pkg::*;
#(
  parameter int IN_CNT   = 2,
  parameter int IN_BITS  = 8,
  parameter int SIGNED   = 0,
  parameter int RST_DATA = 0
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            up_valid,
  output logic                                            up_ready,
  input  logic [IN_CNT*IN_BITS-1:0]                       up_data,
  output logic                                            dn_valid,
  input  logic                                            dn_ready,
  output logic [stage_cnt(IN_CNT, 0)*(IN_BITS+1)-1:0]     dn_data
);

  localparam int OUT_CNT = stage_cnt(IN_CNT, 0);
  localparam int OW      = IN_BITS + 1;

  logic                     valid_q;
  logic [OUT_CNT*OW-1:0]    data_q;
  logic [OUT_CNT*OW-1:0]    sum;

  function automatic logic [OW-1:0] ext(input logic [IN_BITS-1:0] x);
    return (SIGNED != 0) ? {x[IN_BITS-1], x} : {1'b0, x};
  endfunction

  always_comb begin
    sum = '0;
    for (int k = 0; k < IN_CNT / 2; k++) begin
      sum[k*OW +: OW] = ext(up_data[(2*k)*IN_BITS +: IN_BITS])
                      + ext(up_data[(2*k+1)*IN_BITS +: IN_BITS]);
    end
    if (IN_CNT % 2 == 1) begin
      sum[(OUT_CNT-1)*OW +: OW] = ext(up_data[(IN_CNT-1)*IN_BITS +: IN_BITS]);
    end
  end

  // An empty stage always accepts, so bubbles collapse under a downstream stall.
  assign up_ready = !valid_q || dn_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      if (RST_DATA != 0) data_q <= '0;
    end else if (up_ready) begin
      valid_q <= up_valid;
      if (up_valid) data_q <= sum;
    end
  end

  assign dn_valid = valid_q;
  assign dn_data  = data_q;

endmodule

// File: rtl/adder_tree_pipe.sv
// rtl/adder_tree_pipe.sv - NUM-lane pipelined adder tree with backpressure and wrap/saturate narrowing
module adder_tree_pipe
  import adder_pkg::*;
#(
  parameter int NUM    = 4,
  parameter int BITS   = 8,
  parameter int SIGNED = 0,
  parameter int GROW   = 0,
  parameter int SAT    = 0
) (
  input  logic               clk,
  input  logic               rst,
  adder_tree_pipe_if.slave   bus
);

  localparam int LEVELS   = clog2(NUM);
  localparam int SUM_W    = BITS + LEVELS;
  localparam int OUT_BITS = out_bits(BITS, NUM, GROW);

  if (NUM < 2 || NUM > MAX_NUM) begin : g_bad_num
    $fatal(1, "adder_tree_pipe: NUM=%0d outside 2..%0d", NUM, MAX_NUM);
  end

  for (genvar s = 0; s < LEVELS; s++) begin : g_lvl
    localparam int IN_CNT = stage_cnt(NUM, s - 1);
    localparam int IN_W   = BITS + s;
    localparam int DN_W   = stage_cnt(NUM, s) * (IN_W + 1);

    logic [IN_CNT*IN_W-1:0] up_data;
    logic                   up_valid;
    logic                   up_ready;
    logic                   dn_valid;
    logic                   dn_ready;
    logic [DN_W-1:0]        dn_data;

    if (s == 0) begin : g_head
      assign up_data  = bus.in_data;
      assign up_valid = bus.in_valid;
    end else begin : g_link
      assign up_data  = g_lvl[s-1].dn_data;
      assign up_valid = g_lvl[s-1].dn_valid;
    end

    if (s == LEVELS - 1) begin : g_tail
      assign dn_ready = bus.out_ready;
    end else begin : g_mid
      assign dn_ready = g_lvl[s+1].up_ready;
    end

    // The last level doubles as the output register, so its data is reset too.
    adder_tree_stage #(
      .IN_CNT   (IN_CNT),
      .IN_BITS  (IN_W),
      .SIGNED   (SIGNED),
      .RST_DATA ((s == LEVELS - 1) ? 1 : 0)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_valid (up_valid),
      .up_ready (up_ready),
      .up_data  (up_data),
      .dn_valid (dn_valid),
      .dn_ready (dn_ready),
      .dn_data  (dn_data)
    );
  end

  logic [SUM_W-1:0]    sum;
  logic [OUT_BITS-1:0] result;
  logic                ovf;

  assign sum           = g_lvl[LEVELS-1].dn_data;
  assign bus.in_ready  = g_lvl[0].up_ready;
  assign bus.out_valid = g_lvl[LEVELS-1].dn_valid;

  if (GROW != 0) begin : g_grow
    assign result = sum;
    assign ovf    = 1'b0;
  end else begin : g_narrow
    localparam logic [BITS-1:0] SMIN = BITS'(1) << (BITS - 1);
    localparam logic [BITS-1:0] SMAX = ~SMIN;

    logic [SUM_W-BITS:0] head;
    logic [BITS-1:0]     sat_val;

    // A signed value fits iff every bit from the BITS-1 sign position upward agrees.
    assign head    = sum[SUM_W-1:BITS-1];
    assign ovf     = (SIGNED != 0) ? !((&head) || !(|head)) : (|head[SUM_W-BITS:1]);
    assign sat_val = (SIGNED != 0) ? (sum[SUM_W-1] ? SMIN : SMAX) : '1;
    assign result  = (SAT != 0 && ovf) ? sat_val : sum[BITS-1:0];
  end

  assign bus.out_data = result;
  assign bus.out_ovf  = ovf;

endmodule

// File: tb/tb_adder_tree_pipe.sv
// tb/tb_adder_tree_pipe.sv - self-checking bench for adder_tree_pipe across four configurations
module tb_adder_tree_pipe;
  import adder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rst_a;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  adder_tree_pipe_if #(.NUM(4), .BITS(8), .OUT_BITS(8))  ifa();
  adder_tree_pipe_if #(.NUM(4), .BITS(8), .OUT_BITS(8))  ifb();
  adder_tree_pipe_if #(.NUM(5), .BITS(8), .OUT_BITS(8))  ifc();
  adder_tree_pipe_if #(.NUM(5), .BITS(8), .OUT_BITS(11)) ifd();

  adder_tree_pipe #(.NUM(4), .BITS(8), .SIGNED(0), .GROW(0), .SAT(0)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
  adder_tree_pipe #(.NUM(4), .BITS(8), .SIGNED(0), .GROW(0), .SAT(1)) dut_b (.clk(clk), .rst(rst),   .bus(ifb));
  adder_tree_pipe #(.NUM(5), .BITS(8), .SIGNED(1), .GROW(0), .SAT(1)) dut_c (.clk(clk), .rst(rst),   .bus(ifc));
  adder_tree_pipe #(.NUM(5), .BITS(8), .SIGNED(1), .GROW(1), .SAT(0)) dut_d (.clk(clk), .rst(rst),   .bus(ifd));

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint lane_sum(input logic [511:0] d, input int num, input int bits, input int sgn);
    longint s;
    longint v;
    s = 0;
    for (int k = 0; k < num; k++) begin
      v = 0;
      for (int b = 0; b < bits; b++) if (d[k*bits+b]) v += longint'(1) << b;
      if (sgn != 0 && d[k*bits+bits-1]) v -= longint'(1) << bits;
      s += v;
    end
    return s;
  endfunction

  function automatic longint narrow(input longint s, input int bits, input int ow, input int sgn,
                                    input int grow, input int sat, output bit ovf);
    longint lo, hi, r;
    int w;
    lo  = (sgn != 0) ? -(longint'(1) << (bits - 1)) : 0;
    hi  = (sgn != 0) ? (longint'(1) << (bits - 1)) - 1 : (longint'(1) << bits) - 1;
    ovf = (grow == 0) && (s < lo || s > hi);
    r   = s;
    if (ovf && sat != 0) r = (s < lo) ? lo : hi;
    w   = (grow != 0) ? ow : bits;
    return r & ((longint'(1) << w) - 1);
  endfunction

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  int     bv[4][4] = '{'{200, 100, 0, 0}, '{10, 20, 30, 40}, '{255, 1, 0, 0}, '{255, 0, 0, 0}};
  longint bexp[4]  = '{255, 100, 255, 255};
  longint bovf[4]  = '{1, 0, 1, 0};
  int     cv[5][5] = '{'{-100, -100, -100, -100, -100}, '{100, 27, 0, 0, 0}, '{100, 28, 0, 0, 0},
                       '{-128, 0, 0, 0, 0}, '{-128, -1, 0, 0, 0}};
  longint cexp[5]  = '{128, 127, 127, 128, 128};
  longint covf[5]  = '{1, 0, 1, 0, 1};
  longint dexp[5]  = '{1548, 127, 128, 1920, 1919};
  int     av[4][4] = '{'{10, 20, 30, 40}, '{200, 100, 0, 0}, '{255, 255, 255, 255}, '{0, 0, 0, 0}};
  longint aexp[4]  = '{100, 44, 252, 0};
  longint aovf[4]  = '{0, 1, 1, 0};

  // Scoreboard for dut_a: every accepted beat must emerge once, in order, held while stalled.
  longint     exp_d[$];
  bit         exp_o[$];
  int         a_pops = 0;
  bit         holding = 1'b0;
  logic [7:0] held_d;
  logic       held_o;

  always @(negedge clk) begin : mon_a
    longint d;
    bit o;
    if (rst_a) begin
      exp_d.delete();
      exp_o.delete();
      holding = 1'b0;
    end else begin
      if (holding) begin
        check("a_stall_valid", longint'(ifa.out_valid), 1);
        check("a_stall_data", longint'(ifa.out_data), longint'(held_d));
        check("a_stall_ovf", longint'(ifa.out_ovf), longint'(held_o));
      end
      holding = 1'b0;
      if (ifa.out_valid) begin
        if (exp_d.size() == 0) begin
          total++;
          bad++;
          $display("FAIL a_spurious_out: got out_data=%0d with no beat outstanding", ifa.out_data);
        end else if (ifa.out_ready) begin
          d = exp_d.pop_front();
          o = exp_o.pop_front();
          check("a_data", longint'(ifa.out_data), d);
          check("a_ovf", longint'(ifa.out_ovf), longint'(o));
          a_pops++;
        end else begin
          holding = 1'b1;
          held_d  = ifa.out_data;
          held_o  = ifa.out_ovf;
        end
      end
      if (ifa.in_valid && ifa.in_ready) begin
        d = narrow(lane_sum(512'(ifa.in_data), 4, 8, 0), 8, 8, 0, 0, 0, o);
        exp_d.push_back(d);
        exp_o.push_back(o);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, idx, ov, first, last, pops0, nacc;
    bit acc;
    longint md;
    bit mo;

    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.out_ready = 1'b1;
    ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.out_ready = 1'b1;
    ifd.in_valid = 1'b0; ifd.in_data = '0; ifd.out_ready = 1'b1;
    rst = 1'b1;
    rst_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_out_valid", longint'(ifa.out_valid), 0);
    check("rst_a_out_data", longint'(ifa.out_data), 0);
    check("rst_a_out_ovf", longint'(ifa.out_ovf), 0);
    check("rst_c_out_valid", longint'(ifc.out_valid), 0);
    check("rst_d_out_data", longint'(ifd.out_data), 0);
    rst = 1'b0;
    rst_a = 1'b0;
    check("rst_a_in_ready", longint'(ifa.in_ready), 1);
    check("rst_c_in_ready", longint'(ifc.in_ready), 1);

    // Unsigned saturating NUM=4.
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 4; k++) ifb.in_data[k*8 +: 8] = 8'(bv[t][k]);
      ifb.in_valid = 1'b1;
      check("b_in_ready", longint'(ifb.in_ready), 1);
      @(posedge clk); #1;
      ifb.in_valid = 1'b0;
      n = 1;
      while (!ifb.out_valid && n < 20) begin @(posedge clk); #1; n++; end
      check("b_latency", longint'(n), 2);
      check("b_data", longint'(ifb.out_data), bexp[t]);
      check("b_ovf", longint'(ifb.out_ovf), bovf[t]);
      md = narrow(lane_sum(512'(ifb.in_data), 4, 8, 0), 8, 8, 0, 0, 1, mo);
      check("b_model", longint'(ifb.out_data), md);
    end

    // Signed NUM=5: saturating narrow (c) and full-width growth (d) on identical beats.
    for (int t = 0; t < 5; t++) begin
      for (int k = 0; k < 5; k++) begin
        ifc.in_data[k*8 +: 8] = 8'(cv[t][k]);
        ifd.in_data[k*8 +: 8] = 8'(cv[t][k]);
      end
      ifc.in_valid = 1'b1;
      ifd.in_valid = 1'b1;
      @(posedge clk); #1;
      ifc.in_valid = 1'b0;
      ifd.in_valid = 1'b0;
      n = 1;
      while (!ifc.out_valid && n < 20) begin @(posedge clk); #1; n++; end
      check("c_latency", longint'(n), 3);
      check("c_data", longint'(ifc.out_data), cexp[t]);
      check("c_ovf", longint'(ifc.out_ovf), covf[t]);
      md = narrow(lane_sum(512'(ifc.in_data), 5, 8, 1), 8, 8, 1, 0, 1, mo);
      check("c_model", longint'(ifc.out_data), md);
      check("d_valid", longint'(ifd.out_valid), 1);
      check("d_data", longint'(ifd.out_data), dexp[t]);
      check("d_ovf", longint'(ifd.out_ovf), 0);
      md = narrow(lane_sum(512'(ifd.in_data), 5, 8, 1), 8, 11, 1, 1, 0, mo);
      check("d_model", longint'(ifd.out_data), md);
    end

    // Unsigned wrapping NUM=4: latency and literal sums.
    for (int t = 0; t < 4; t++) begin
      ifa.in_data = pack4(av[t][0], av[t][1], av[t][2], av[t][3]);
      ifa.in_valid = 1'b1;
      check("a_in_ready", longint'(ifa.in_ready), 1);
      @(posedge clk); #1;
      ifa.in_valid = 1'b0;
      n = 1;
      while (!ifa.out_valid && n < 20) begin @(posedge clk); #1; n++; end
      check("a_latency", longint'(n), 2);
      check("a_sum_literal", longint'(ifa.out_data), aexp[t]);
      check("a_ovf_literal", longint'(ifa.out_ovf), aovf[t]);
    end

    // Back-to-back beats give one result per cycle.
    ov = 0; first = -1; last = -1;
    for (int c = 0; c < 12; c++) begin
      if (c < 6) begin
        ifa.in_data = pack4(c, 2 * c, 3 * c, 40 * c + 1);
        ifa.in_valid = 1'b1;
        check("a_b2b_in_ready", longint'(ifa.in_ready), 1);
      end else begin
        ifa.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (ifa.out_valid) begin
        ov++;
        if (first < 0) first = c;
        last = c;
      end
    end
    check("a_b2b_count", longint'(ov), 6);
    check("a_b2b_run", longint'(last - first + 1), 6);

    // Backpressure: 8 beats against a 5-cycle output stall.
    pops0 = a_pops;
    idx = 0;
    ifa.out_ready = 1'b0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      if (c == 5) begin
        check("a_bp_in_ready_low", longint'(ifa.in_ready), 0);
        check("a_bp_absorbed", longint'(idx), 2);
        ifa.out_ready = 1'b1;
      end
      ifa.in_data = pack4(60 * idx, idx, 7, 1);
      ifa.in_valid = 1'b1;
      #1;
      acc = ifa.in_valid && ifa.in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    ifa.in_valid = 1'b0;
    check("a_bp_all_sent", longint'(idx), 8);
    repeat (6) @(posedge clk);
    #1;
    check("a_bp_all_out", longint'(a_pops - pops0), 8);

    // Bubble collapse: valid 1,0,1 while the output is stalled.
    ifa.out_ready = 1'b0;
    nacc = 0;
    for (int c = 0; c < 3; c++) begin
      ifa.in_valid = (c != 1);
      ifa.in_data = pack4(11 * c + 5, 3, 2, 1);
      #1;
      if (ifa.in_valid && ifa.in_ready) nacc++;
      @(posedge clk); #1;
    end
    ifa.in_valid = 1'b0;
    check("a_bubble_accepted", longint'(nacc), 2);
    check("a_bubble_out_valid", longint'(ifa.out_valid), 1);
    check("a_bubble_full", longint'(ifa.in_ready), 0);
    ifa.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Reset with two beats in flight flushes them.
    pops0 = a_pops;
    for (int c = 0; c < 2; c++) begin
      ifa.in_data = pack4(c + 90, 1, 1, 1);
      ifa.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    ifa.in_valid = 1'b0;
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    check("a_flush_out_valid", longint'(ifa.out_valid), 0);
    check("a_flush_in_ready", longint'(ifa.in_ready), 1);
    ov = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ifa.out_valid) ov++;
    end
    check("a_flush_no_out", longint'(ov), 0);
    check("a_flush_pops", longint'(a_pops - pops0), 0);

    ifa.in_data = pack4(1, 2, 3, 4);
    ifa.in_valid = 1'b1;
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    n = 1;
    while (!ifa.out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("a_post_flush_data", longint'(ifa.out_data), 10);
    repeat (3) @(posedge clk);
    #1;
    check("a_queue_empty", longint'(exp_d.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_tree_pipe.md
Name: adder_tree_pipe

Overview:
- Parametrised successor to the fixed 2/4-input valid-only adder: sums NUM lanes of BITS each in a pipelined binary tree.
- Full valid/ready backpressure, with per-stage bubble collapsing.
- Configurable signedness, output width growth, and wrap or saturate on narrowing.
- Sits between data producers and accumulation/reduction consumers wherever multi-operand sums are needed.

Parameters:
- NUM, 4: number of input lanes, legal range 2..64.
- BITS, 8: lane width in bits, at least 1.
- SIGNED, 0: 1 = two's-complement operands and result; 0 = unsigned.
- GROW, 0: 1 = OUT_BITS = BITS+LEVELS, so no overflow is possible; 0 = OUT_BITS = BITS.
- SAT, 0: only used when GROW=0. 1 = clamp to min/max of OUT_BITS; 0 = wrap modulo 2^BITS.

Ports:
- clk, input, 1: clock, all logic rising-edge.
- rst, input, 1: reset, synchronous, active-high.
- in_valid, input, 1: input beat present.
- in_ready, output, 1: block accepts the beat this cycle.
- in_data, input, NUM*BITS: lane k is in_data[k*BITS +: BITS].
- out_valid, output, 1: result present.
- out_ready, input, 1: consumer accepts the result.
- out_data, output, OUT_BITS: the sum.
- out_ovf, output, 1: the sum did not fit in BITS. Qualified by out_valid. Always 0 when GROW=1.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
- Reset: all stage valid bits clear. out_valid=0, out_data=0, out_ovf=0. in_ready=1 in the first cycle after rst deasserts.
- Reset mid-operation flushes every in-flight beat with no output. Data registers need not be reset; the output register is reset.
- Structure: LEVELS = clog2(NUM) register stages; stage s holds ceil(NUM/2^(s+1)) partial sums.
- Odd partial-sum count at a level: the last element passes through unmodified, sign- or zero-extended.
- Internal width: stage s values are BITS+s+1 bits wide, extended per SIGNED, so there is no internal overflow.
- Latency: LEVELS cycles from accepted input to out_valid, when there is no stall. NUM=4 gives 2 cycles; NUM=5 gives 3. Throughput is 1 beat/cycle.
- Handshake, per stage: ready[s] = !v[s] || ready[s+1], with ready[LEVELS] = out_ready.
- Stage s loads when ready[s]. Its v[s] is set from the upstream valid of that cycle.
- in_ready = ready[0]. A beat transfers when in_valid && in_ready; likewise at the output.
- No combinational path from in_valid to in_ready.
- in_ready depends combinationally on out_ready through the ready chain. This is accepted.
- Stall: while out_valid && !out_ready, out_data and out_ovf hold stable and no beat is lost.
- Upstream stages keep filling until every v is set; in_ready then drops.
- Bubbles: an empty stage always accepts, so a gap upstream of a stall is absorbed.
- Final narrowing, applied in the last stage on the full-width sum S (GROW=0):
  - out_ovf = S outside the range of a BITS-wide value (signed or unsigned per SIGNED).
  - SAT=1 and overflow: out_data = max or min representable value, chosen by the sign of S. Unsigned underflow is impossible.
  - SAT=0: out_data = S[BITS-1:0].
- Simultaneous output drain and input accept in the same cycle is legal at every stage. No duplication and no drop is allowed.
- Ordering: strictly FIFO.
- Elaboration: NUM<2 or NUM>64 fails with a fatal message.

Decomposition:
- Package adder_pkg holds:
  - function clog2;
  - function out_bits(BITS, NUM, GROW);
  - function stage_cnt(NUM, s) = ceil(NUM/2^(s+1));
  - localparam MAX_NUM = 64.
- Sub-module adder_tree_stage(IN_CNT, IN_BITS, SIGNED): one tree level. Pairwise adds with an odd pass-through, a valid bit and the local ready equation.
- The top instantiates LEVELS adder_tree_stage instances via generate, then the narrowing/saturation logic.

Test Plan:
- NUM=4, BITS=8, unsigned, GROW=0, SAT=0, out_ready=1. Inputs 10, 20, 30, 40 -> out_data=100, ovf=0, exactly 2 cycles after acceptance. Back-to-back beats each give a result every cycle.
- Same configuration, inputs 200, 100, 0, 0 -> out_data=44 (300 mod 256), out_ovf=1. With SAT=1 -> out_data=255, out_ovf=1.
- NUM=5, BITS=8, SIGNED=1, SAT=1, inputs -100 x5 -> out_data=-128 (0x80), ovf=1, latency 3. With GROW=1 -> out_data=-500 in 11 bits, ovf=0.
- Backpressure: stream 8 beats with distinct sums and hold out_ready=0 for 5 cycles. Required: in_ready drops after LEVELS+... all stages full; out_data stays stable; afterwards all 8 sums emerge in order with no loss or duplicate.
- Bubble collapse: in_valid pulsing 1,0,1 while out_ready=0. Both beats are absorbed and the gap does not block acceptance.
- Reset mid-stream: assert rst for 1 cycle with 2 beats in flight. Next cycle out_valid=0 and in_ready=1; the flushed sums never appear.
